hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Produces the stall/clr controls consumed by the IF/ID and ID/EX pipeline registers and the PC.
//  Covers load-use hazards, taken branch/jump flushes and memory-wait freezes.
//  Sits between decode (ID-side operands) and the ID/EX register outputs (EX-side operands).
//  Keeps saturating stall/flush performance counters.
// PARAMETERS
//  FLUSH_CYCLES  1   cycles IF/ID and ID/EX are cleared per accepted redirect (legal 1..7)
//  CNT_W         16  width of performance counters
// PORTS
//  clk           in   1      pipeline clock; all state updates on posedge
//  rst_n         in   1      synchronous reset, active low
//  id_rs1        in   5      rs1 index of instruction in ID
//  id_rs2        in   5      rs2 index of instruction in ID
//  id_uses_rs2   in   1      ID instruction reads rs2 (R/S/B types)
//  ex_rd         in   5      rd of instruction in EX (ID/EX rd_out)
//  ex_mem_read   in   1      EX instruction is a load (ID/EX datapath_out mem_read bit)
//  ex_redirect   in   1      EX resolves taken branch or jump this cycle
//  mem_busy      in   1      data memory not ready; whole pipeline must freeze
//  pc_stall      out  1      hold PC
//  ifid_stall    out  1      hold IF/ID
//  ifid_clr      out  1      clear IF/ID
//  idex_stall    out  1      hold ID/EX (ID/EX raises bubble)
//  idex_clr      out  1      clear ID/EX (inserts NOP)
//  stall_cycles  out  CNT_W  cycles with pc_stall=1, saturating
//  flush_events  out  CNT_W  accepted redirects, saturating
// BEHAVIOUR
//  - Control outputs combinational from inputs + state; state and counters registered.
//  - Invariant: never idex_stall&idex_clr, never ifid_stall&ifid_clr (ID/EX stall beats clr).
//  - rst_n=0: ifid_clr=idex_clr=1, all stalls 0; next edge: state=RUN, fcnt=0, saved=0, counters=0.
//  - States: RUN, FLUSH (fcnt = remaining clear cycles), WAIT (frozen; saved = fcnt at entry).
//  - Priority per cycle: reset > mem_busy > ex_redirect > load-use.
//  - mem_busy=1 (any state): pc/ifid/idex_stall=1, no clr; -> WAIT, saved<=fcnt from RUN/FLUSH.
//  - WAIT & !mem_busy: evaluate as RUN if saved=0, else as FLUSH with fcnt=saved (count frozen, not lost).
//  - ex_redirect (not busy): ifid_clr=idex_clr=1, pc free (loads target); flush_events+1;
//    FLUSH_CYCLES=1 -> RUN, else -> FLUSH with fcnt=FLUSH_CYCLES-1. Redirect in FLUSH restarts fcnt.
//  - FLUSH (no busy/redirect): ifid_clr=idex_clr=1; fcnt-1; fcnt reaching 0 -> RUN. Load-use ignored.
//  - load-use (RUN only): ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | id_uses_rs2&ex_rd==id_rs2)
//    -> pc_stall=ifid_stall=1, idex_clr=1 for that cycle; no state change (hazard clears as load leaves EX).
//  - ex_rd=0 never hazards. Redirect and load-use in same cycle: redirect only.
//  - Counters increment at edge of qualifying cycle; hold at 2^CNT_W-1; reset only by rst_n.
// TESTING
//  1 rst_n=0 2 cycles -> clr=1 both, stalls=0; after release all outputs 0, counters 0.
//  2 ex_mem_read=1, ex_rd=5, id_rs1=5 -> pc_stall=ifid_stall=idex_clr=1 one cycle; stall_cycles=1;
//    id_rs2=5,id_uses_rs2=0 -> no stall; ex_rd=0 -> no stall.
//  3 FLUSH_CYCLES=2, ex_redirect 1 cycle -> clr both for 2 cycles, pc_stall=0, flush_events=1.
//  4 FLUSH_CYCLES=3, redirect then mem_busy 4 cycles in FLUSH -> all stalls 4 cycles, then clr 2 more.
//  5 redirect + load-use same cycle -> clr only, no pc_stall; 65540 stall cycles -> stall_cycles=0xFFFF.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode/EX operand inputs and pipeline stall/clear controls of the hazard unit
interface hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_uses_rs2, ex_mem_read, ex_redirect, mem_busy;
  logic pc_stall, ifid_stall, ifid_clr, idex_stall, idex_clr;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  modport master (
    output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, ex_redirect, mem_busy,
    input pc_stall, ifid_stall, ifid_clr, idex_stall, idex_clr, stall_cycles, flush_events
  );
  modport slave (
    input id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read, ex_redirect, mem_busy,
    output pc_stall, ifid_stall, ifid_clr, idex_stall, idex_clr, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stalls, redirect flushes and memory-wait freezes with saturating perf counters
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_WAIT} state_t;
  localparam logic [2:0] FC_M1 = 3'(FLUSH_CYCLES - 1);
  state_t state, state_n;
  logic [2:0] fcnt, fcnt_n, saved, saved_n, eff_cnt;
  logic eff_flush, load_use, busy, redir, lu, fl;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  // a released WAIT resumes whatever flush count was frozen at entry
  always_comb begin
    eff_flush = state == S_FLUSH || (state == S_WAIT && saved != 3'd0);
    eff_cnt = state == S_WAIT ? saved : fcnt;
    load_use = hz.ex_mem_read && hz.ex_rd != 5'd0 && !eff_flush &&
               (hz.ex_rd == hz.id_rs1 || (hz.id_uses_rs2 && hz.ex_rd == hz.id_rs2));
    busy = rst_n && hz.mem_busy;
    redir = rst_n && !hz.mem_busy && hz.ex_redirect;
    lu = rst_n && !hz.mem_busy && !hz.ex_redirect && load_use;
    fl = rst_n && !hz.mem_busy && !hz.ex_redirect && eff_flush;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_RUN;
      fcnt <= 3'd0;
      saved <= 3'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_n;
      fcnt <= fcnt_n;
      saved <= saved_n;
      if (hz.pc_stall && ~&stall_cnt) stall_cnt <= stall_cnt + CNT_W'(1);
      if (redir && ~&flush_cnt) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
  always_comb begin
    state_n = state;
    fcnt_n = fcnt;
    saved_n = saved;
    if (hz.mem_busy) begin
      state_n = S_WAIT;
      saved_n = state == S_WAIT ? saved : fcnt;
    end else if (hz.ex_redirect) begin
      state_n = FLUSH_CYCLES == 1 ? S_RUN : S_FLUSH;
      fcnt_n = FC_M1;
    end else if (eff_flush) begin
      state_n = eff_cnt == 3'd1 ? S_RUN : S_FLUSH;
      fcnt_n = eff_cnt - 3'd1;
    end else begin
      state_n = S_RUN;
      fcnt_n = 3'd0;
    end
  end
  always_comb begin
    hz.pc_stall = busy || lu;
    hz.ifid_stall = busy || lu;
    hz.idex_stall = busy;
    hz.ifid_clr = !rst_n || redir || fl;
    hz.idex_clr = !rst_n || redir || fl || lu;
    hz.stall_cycles = stall_cnt;
    hz.flush_events = flush_cnt;
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of two hazard_ctrl instances (FLUSH_CYCLES 2 and 3) on shared stimulus
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  hazard_ctrl_if #(.CNT_W(16)) i2 ();
  hazard_ctrl_if #(.CNT_W(16)) i3 ();
  hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) u2 (.clk(clk), .rst_n(rst_n), .hz(i2));
  hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(16)) u3 (.clk(clk), .rst_n(rst_n), .hz(i3));
  assign i3.id_rs1 = i2.id_rs1;
  assign i3.id_rs2 = i2.id_rs2;
  assign i3.id_uses_rs2 = i2.id_uses_rs2;
  assign i3.ex_rd = i2.ex_rd;
  assign i3.ex_mem_read = i2.ex_mem_read;
  assign i3.ex_redirect = i2.ex_redirect;
  assign i3.mem_busy = i2.mem_busy;
  logic [4:0] c2, c3;
  assign c2 = {i2.pc_stall, i2.ifid_stall, i2.ifid_clr, i2.idex_stall, i2.idex_clr};
  assign c3 = {i3.pc_stall, i3.ifid_stall, i3.ifid_clr, i3.idex_stall, i3.idex_clr};
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2s,
                       input logic [4:0] rd, input logic mr, input logic rdr, input logic busy);
    i2.id_rs1 = rs1;
    i2.id_rs2 = rs2;
    i2.id_uses_rs2 = u2s;
    i2.ex_rd = rd;
    i2.ex_mem_read = mr;
    i2.ex_redirect = rdr;
    i2.mem_busy = busy;
    #1;
  endtask
  localparam logic [4:0] NONE = 5'b00000, CLR = 5'b00101, LU = 5'b11001, FRZ = 5'b11010;
  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("reset_ctrl_u2", 32'(c2), 32'(CLR));
    chk("reset_ctrl_u3", 32'(c3), 32'(CLR));
    cyc();
    cyc();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("run_idle_u2", 32'(c2), 32'(NONE));
    chk("run_idle_u3", 32'(c3), 32'(NONE));
    chk("reset_stall_cnt", 32'(i2.stall_cycles), 0);
    chk("reset_flush_cnt", 32'(i3.flush_events), 0);
    drive(5, 0, 0, 5, 1, 0, 0);
    chk("lu_rs1", 32'(c2), 32'(LU));
    cyc();
    drive(1, 5, 0, 5, 1, 0, 0);
    chk("lu_rs2_unused", 32'(c2), 32'(NONE));
    chk("stall_cnt_1", 32'(i2.stall_cycles), 1);
    cyc();
    drive(1, 5, 1, 5, 1, 0, 0);
    chk("lu_rs2_used", 32'(c3), 32'(LU));
    cyc();
    drive(0, 0, 1, 0, 1, 0, 0);
    chk("lu_rd0", 32'(c2), 32'(NONE));
    drive(5, 0, 0, 5, 0, 0, 0);
    chk("no_load", 32'(c2), 32'(NONE));
    chk("stall_cnt_2", 32'(i3.stall_cycles), 2);
    cyc();
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("redir_u2", 32'(c2), 32'(CLR));
    chk("redir_u3", 32'(c3), 32'(CLR));
    cyc();
    drive(5, 0, 0, 5, 1, 0, 0);
    chk("flush_lu_ignored_u2", 32'(c2), 32'(CLR));
    chk("flush_lu_ignored_u3", 32'(c3), 32'(CLR));
    chk("flush_cnt_1", 32'(i2.flush_events), 1);
    cyc();
    chk("fc2_done_lu_u2", 32'(c2), 32'(LU));
    chk("fc3_third_clr_u3", 32'(c3), 32'(CLR));
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("fc3_done_u3", 32'(c3), 32'(NONE));
    chk("stall_cnt_u2_3", 32'(i2.stall_cycles), 3);
    chk("stall_cnt_u3_2", 32'(i3.stall_cycles), 2);
    drive(0, 0, 0, 0, 0, 1, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("flush_cnt_2", 32'(i3.flush_events), 2);
    for (int i = 0; i < 4; i++) begin
      chk("busy_in_flush_u3", 32'(c3), 32'(FRZ));
      chk("busy_in_flush_u2", 32'(c2), 32'(FRZ));
      cyc();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("resume_u3_a", 32'(c3), 32'(CLR));
    chk("resume_u2_a", 32'(c2), 32'(CLR));
    cyc();
    chk("resume_u3_b", 32'(c3), 32'(CLR));
    chk("resume_u2_done", 32'(c2), 32'(NONE));
    cyc();
    chk("resume_u3_done", 32'(c3), 32'(NONE));
    chk("stall_cnt_u2_7", 32'(i2.stall_cycles), 7);
    chk("stall_cnt_u3_6", 32'(i3.stall_cycles), 6);
    drive(0, 0, 0, 0, 0, 1, 1);
    chk("busy_beats_redir", 32'(c2), 32'(FRZ));
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("wait_exit_run", 32'(c3), 32'(NONE));
    chk("busy_redir_no_flush", 32'(i2.flush_events), 2);
    drive(5, 0, 0, 5, 1, 1, 0);
    chk("redir_beats_lu_u2", 32'(c2), 32'(CLR));
    chk("redir_beats_lu_u3", 32'(c3), 32'(CLR));
    cyc();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("flush_cnt_3", 32'(i3.flush_events), 3);
    chk("stall_cnt_u2_8", 32'(i2.stall_cycles), 8);
    cyc();
    cyc();
    drive(7, 0, 0, 7, 1, 0, 0);
    chk("sat_start_lu", 32'(c3), 32'(LU));
    repeat (65540) @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("stall_sat_u2", 32'(i2.stall_cycles), 32'hFFFF);
    chk("stall_sat_u3", 32'(i3.stall_cycles), 32'hFFFF);
    cyc();
    chk("stall_sat_hold", 32'(i2.stall_cycles), 32'hFFFF);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 1);
    chk("reset_beats_busy", 32'(c2), 32'(CLR));
    cyc();
    chk("reset_clears_stall", 32'(i2.stall_cycles), 0);
    chk("reset_clears_flush", 32'(i3.flush_events), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
